// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear stopwatch with prescaled 1 s tick and M:SS BCD chain
module stopwatch_ctrl #(
   parameter int TICK_DIV = 50000000,
   parameter int MAX_MIN  = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic          ss_q, lap_q, clr_q;
   logic          raw_ss, raw_lap, raw_clr;
   logic          ev_ss, ev_lap, ev_clr;
   logic          clear_req;
   logic          counting, tick;
   logic [PW-1:0] presc_q;
   logic [3:0]    sec1_q, sec10_q, min_q;
   logic [3:0]    disp0_q, disp1_q, disp2_q;
   logic          ovf_q;

   // Rising-edge events, then priority ss > lap > clr drops the losers.
   always_comb begin
      raw_ss  = btn_ss  & ~ss_q;
      raw_lap = btn_lap & ~lap_q;
      raw_clr = btn_clr & ~clr_q;
      ev_ss   = raw_ss;
      ev_lap  = raw_lap & ~raw_ss;
      ev_clr  = raw_clr & ~raw_ss & ~raw_lap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clear_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ev_ss) state_d = S_RUN;
         end
         S_RUN: begin
            if (ev_ss)       state_d = S_PAUSE;
            else if (ev_lap) state_d = S_LAP;
         end
         S_LAP: begin
            if (ev_ss)       state_d = S_PAUSE;
            else if (ev_lap) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (ev_ss) begin
               state_d = S_RUN;
            end else if (ev_clr) begin
               state_d   = S_IDLE;
               clear_req = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign counting = (state_q == S_RUN) || (state_q == S_LAP);
   assign tick     = counting && (presc_q == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_q    <= btn_ss;
         lap_q   <= btn_lap;
         clr_q   <= btn_clr;
         presc_q <= '0;
         sec1_q  <= 4'd0;
         sec10_q <= 4'd0;
         min_q   <= 4'd0;
         ovf_q   <= 1'b0;
         disp0_q <= 4'd0;
         disp1_q <= 4'd0;
         disp2_q <= 4'd0;
      end else begin
         ss_q  <= btn_ss;
         lap_q <= btn_lap;
         clr_q <= btn_clr;

         if (clear_req) begin
            presc_q <= '0;
            sec1_q  <= 4'd0;
            sec10_q <= 4'd0;
            min_q   <= 4'd0;
            ovf_q   <= 1'b0;
         end else if (counting) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               if (sec1_q == 4'd9) begin
                  sec1_q <= 4'd0;
                  if (sec10_q == 4'd5) begin
                     sec10_q <= 4'd0;
                     if (min_q == 4'(MAX_MIN)) begin
                        min_q <= 4'd0;
                        ovf_q <= 1'b1;
                     end else begin
                        min_q <= min_q + 4'd1;
                     end
                  end else begin
                     sec10_q <= sec10_q + 4'd1;
                  end
               end else begin
                  sec1_q <= sec1_q + 4'd1;
               end
            end
         end

         // Display follows the pre-edge live count except while a lap is frozen.
         if (state_q != S_LAP) begin
            disp0_q <= sec1_q;
            disp1_q <= sec10_q;
            disp2_q <= min_q;
         end
      end
   end

   assign digit0     = disp0_q;
   assign digit1     = disp1_q;
   assign digit2     = disp2_q;
   assign running    = counting;
   assign lap_active = (state_q == S_LAP);
   assign overflow   = ovf_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/lap/clear controller for the minute:second display counter (M:SS).
- Takes three debounced push-button levels and the system clock. Generates its own 1 s tick from a prescaler and runs the BCD time chain under a 4-state FSM.
- Drives three 4-bit BCD digits that feed the existing seg7 decoders.
- Replaces the free-running divider/counter chain where start/stop/lap control is needed.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick (minimum 2).
- MAX_MIN, 9, largest minute value before wrap (0..9).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_ss  input  1  start/stop button level, debounced and synchronous to clk.
- btn_lap  input  1  lap/split button level, debounced and synchronous.
- btn_clr  input  1  clear button level, debounced and synchronous.
- digit0  output  4  displayed seconds ones, BCD 0-9.
- digit1  output  4  displayed seconds tens, BCD 0-5.
- digit2  output  4  displayed minutes, 0..MAX_MIN.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP (display frozen).
- overflow  output  1  sticky; set when time wraps past MAX_MIN:59.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE; prescaler, live counters, display registers and overflow all 0; edge-detect history registers load the current button levels, so a button already held produces no event.
- Edge detect: event = level & ~prev, one cycle wide. A held button produces exactly one event.
- Event priority when several occur in one cycle: ss > lap > clr. Lower-priority events in that cycle are discarded.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: ss -> RUN. lap and clr are ignored.
  - RUN: ss -> PAUSE. lap -> LAP and freezes the display. clr is ignored.
  - LAP: lap -> RUN (display returns to live). ss -> PAUSE (display returns to live). clr is ignored. Counting continues in LAP.
  - PAUSE: ss -> RUN. clr -> IDLE, clearing prescaler, live counters and overflow. lap is ignored.
- Prescaler:
  - Counts only while the registered state is RUN or LAP. Holds its value in PAUSE, so phase is preserved across pause/resume.
  - On reaching TICK_DIV-1 it wraps to 0 and asserts tick for that cycle.
  - The first tick after leaving IDLE occurs exactly TICK_DIV cycles after the state register becomes RUN.
- Time chain, on tick only:
  - sec1 increments. 9 -> 0 carries into sec10.
  - sec10 5 -> 0 carries into min.
  - min MAX_MIN -> 0 sets overflow. Counting continues from 0:00.
- Gating uses the current state register. A tick coinciding with the ss event that leaves RUN is still applied.
- Display registers: every cycle not in LAP, load the live counters. The display therefore lags the live count by 1 cycle.
  - In LAP they hold the value captured on the cycle the lap event was accepted, i.e. the live value at that edge.
- running and lap_active decode the state register directly. They change on the edge after the event cycle.
- overflow stays set until a clear in PAUSE or rst. A rst mid-count behaves exactly as the reset from any state.
- Invariants: digits are never outside their BCD ranges; no X on any output after the first reset edge.

Test Plan (TICK_DIV=4, MAX_MIN=9):
- Reset and start: rst 2 cycles, pulse btn_ss.
  - Digits stay 0:00 until tick.
  - running=1 one cycle after the event.
  - digit0=1 appears 4 cycles after RUN entry plus 1 cycle display lag.
- Carry chain: run 59 ticks, then 1 more.
  - Display 0:59 after 59 ticks.
  - After the 60th tick: digit2=1, digit1=0, digit0=0.
- Pause/resume phase: ss after 2 prescaler cycles, wait 20 cycles, ss again.
  - Count is frozen during PAUSE.
  - The next tick arrives after 2 more RUN cycles.
  - clr while in RUN is ignored.
- Lap:
  - In RUN at 0:07, press lap: display holds 0:07 and lap_active=1 for 10 ticks.
  - Press lap again: display shows live 0:17 after 1 cycle.
- Overflow and clear:
  - Run to 9:59, one more tick: display 0:00, overflow=1.
  - ss then clr: IDLE, 0:00, overflow=0.
- Simultaneous and held buttons:
  - ss and clr same cycle in PAUSE: goes to RUN, clr dropped.
  - btn_ss held high through rst release: no start.
  - Holding btn_ss 50 cycles toggles the state once.
